// File: rtl/imem_responder.sv
// Instruction-memory responder: takes one fetch request at a time, reads the
// aligned doubleword from a synchronous SRAM and returns it (or an access fault).
module imem_responder #(
   parameter logic [31:0] BASE      = 32'h8000_0000,
   parameter int          SIZE_LOG2 = 16,
   parameter int          LATENCY   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_addr,
   input  logic                 req_cancel,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [63:0]          resp_rdata,
   output logic                 resp_err,
   output logic                 sram_en,
   output logic [SIZE_LOG2-4:0] sram_addr,
   input  logic [63:0]          sram_rdata
);

   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [CW-1:0]         lat_cnt;
   logic                  discard;
   logic [SIZE_LOG2-4:0]  addr_q;
   logic [32:0]           offset;
   logic                  in_range;
   logic                  aligned;
   logic                  accept;
   logic                  accept_good;
   logic                  unused_offset;

   // A borrow into bit 32 means the address lies below BASE, so one zero test
   // over the upper bits covers both ends of the window without wrap-around.
   assign offset        = {1'b0, req_addr} - {1'b0, BASE};
   assign in_range      = (offset[32:SIZE_LOG2] == '0);
   assign aligned       = (req_addr[1:0] == 2'b00);
   assign unused_offset = ^offset[2:0];

   assign req_ready   = (state == IDLE);
   assign accept      = req_valid && req_ready;
   assign accept_good = accept && in_range && aligned;

   // The SRAM sees the index in the accept cycle itself; afterwards it holds.
   assign sram_en   = accept_good;
   assign sram_addr = accept_good ? offset[SIZE_LOG2-1:3] : addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         discard    <= 1'b0;
         lat_cnt    <= '0;
         addr_q     <= '0;
      end else begin
         if (accept_good) begin
            addr_q <= offset[SIZE_LOG2-1:3];
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_range && aligned) begin
                     state   <= WAIT;
                     lat_cnt <= CW'(LATENCY);
                     discard <= 1'b0;
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - CW'(1);
               // Count of one marks the cycle the SRAM data is valid; a flushed
               // fetch lets the read finish but never raises resp_valid.
               if (lat_cnt == CW'(1)) begin
                  discard <= 1'b0;
                  if (discard || req_cancel) begin
                     state <= IDLE;
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= sram_rdata;
                  end
               end else if (req_cancel) begin
                  discard <= 1'b1;
               end
            end
            RESP: begin
               if (resp_ready || req_cancel) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (latency 1, 2, 3) against a
// behavioural SRAM and a timeline model of each fetch.
module tb_imem_responder;

   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          SIZE_LOG2 = 16;
   localparam int          AW        = SIZE_LOG2 - 3;
   localparam int          NWORDS    = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [3];
   logic [31:0] req_addr   [3];
   logic        req_cancel [3];
   logic        resp_ready [3];
   wire         req_ready  [3];
   wire         resp_valid [3];
   wire  [63:0] resp_rdata [3];
   wire         resp_err   [3];
   wire         sram_en    [3];
   wire [AW-1:0] sram_addr [3];

   logic [63:0] mem [NWORDS];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   // Each instance gets its own SRAM pipeline of depth LATENCY; cycles without
   // a read push junk so a mistimed capture shows up as wrong data.
   for (genvar g = 0; g < 3; g++) begin : g_inst
      logic [63:0] pipe [g+1];
      always @(posedge clk) begin
         pipe[0] <= sram_en[g] ? mem[sram_addr[g]] : {$urandom, $urandom};
         for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
      end
      imem_responder #(.BASE(BASE), .SIZE_LOG2(SIZE_LOG2), .LATENCY(g + 1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_addr   (req_addr[g]),
         .req_cancel (req_cancel[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g]),
         .sram_en    (sram_en[g]),
         .sram_addr  (sram_addr[g]),
         .sram_rdata (pipe[g])
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_err(input logic [31:0] a);
      longint x, lo, hi;
      x  = longint'(a);
      lo = longint'(BASE);
      hi = lo + (longint'(1) << SIZE_LOG2);
      return (x < lo) || (x >= hi) || (a[1:0] != 2'b00);
   endfunction

   function automatic logic [AW-1:0] ref_idx(input logic [31:0] a);
      return AW'((longint'(a) - longint'(BASE)) >> 3);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] good;
      good = BASE + 32'($urandom_range(0, NWORDS - 1)) * 32'd8 + 32'($urandom_range(0, 1)) * 32'd4;
      case ($urandom_range(0, 9))
         6:       return good + 32'($urandom_range(1, 3));
         7:       return BASE - 32'($urandom_range(1, 64)) * 32'd4;
         8:       return BASE + 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd4;
         9: begin
            case ($urandom_range(0, 4))
               0:       return BASE + 32'h0000_FFF8;
               1:       return BASE + 32'h0000_FFFC;
               2:       return BASE + 32'h0001_0000;
               3:       return BASE - 32'd4;
               default: return 32'hFFFF_FFFC;
            endcase
         end
         default: return good;
      endcase
   endfunction

   // One fetch on instance g, starting just after a rising edge while idle.
   // cancel_at is the cycle (relative to accept) carrying req_cancel, -1 for none;
   // hold is how many cycles resp_ready stays low once the response is due.
   // Returns at the first idle cycle so the next fetch can be back-to-back.
   task automatic fetch(input int g, input logic [31:0] addr, input int hold, input int cancel_at);
      int            lat, r, e, idle;
      bit            err, dropped, vis;
      logic [63:0]   exp_data;
      logic [AW-1:0] idx;
      string         t;
      lat      = g + 1;
      err      = ref_err(addr);
      idx      = ref_idx(addr);
      exp_data = err ? 64'd0 : mem[idx];
      r        = err ? 1 : lat + 1;
      dropped  = !err && cancel_at >= 1 && cancel_at <= lat;
      e        = r + hold;
      if (cancel_at >= r && cancel_at < e) e = cancel_at;
      idle     = dropped ? lat + 1 : e + 1;
      for (int c = 0; c < idle; c++) begin
         req_valid[g]  = (c == 0) ? 1'b1 : 1'($urandom & 1);
         req_addr[g]   = (c == 0) ? addr : $urandom;
         req_cancel[g] = (c == cancel_at);
         resp_ready[g] = (c >= r + hold);
         @(negedge clk);
         t   = $sformatf("u%0d a%h c%0d", g, addr, c);
         vis = !dropped && c >= r && c <= e;
         chk({t, " req_ready"}, req_ready[g], c == 0);
         chk({t, " sram_en"}, sram_en[g], c == 0 && !err);
         if (!err) chk({t, " sram_addr"}, sram_addr[g], idx);
         chk({t, " resp_valid"}, resp_valid[g], vis);
         if (vis) begin
            chk({t, " resp_rdata"}, resp_rdata[g], exp_data);
            chk({t, " resp_err"}, resp_err[g], err);
         end
         @(posedge clk);
         #1;
      end
      req_valid[g]  = 1'b0;
      req_cancel[g] = 1'b0;
      resp_ready[g] = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s u%0d req_ready", tag, g), req_ready[g], 1'b1);
         chk($sformatf("%s u%0d resp_valid", tag, g), resp_valid[g], 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   // Reset while the latency-3 instance waits on the SRAM; the read must vanish.
   task automatic reset_during_wait(input logic [31:0] addr);
      req_valid[2] = 1'b1;
      req_addr[2]  = addr;
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstwait resp_valid", resp_valid[2], 1'b0);
      chk("rstwait resp_err", resp_err[2], 1'b0);
      chk("rstwait resp_rdata", resp_rdata[2], 64'd0);
      chk("rstwait sram_en", sram_en[2], 1'b0);
      chk("rstwait req_ready", req_ready[2], 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk($sformatf("rstwait late%0d resp_valid", i), resp_valid[2], 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g, lat, cancel_at;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid[i]  = 1'b0;
         req_addr[i]   = 32'd0;
         req_cancel[i] = 1'b0;
         resp_ready[i] = 1'b0;
      end
      for (int i = 0; i < NWORDS; i++) mem[i] = {$urandom, $urandom};
      mem[0] = 64'h0000_0013_0010_0093;

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset u%0d resp_valid", i), resp_valid[i], 1'b0);
         chk($sformatf("reset u%0d resp_err", i), resp_err[i], 1'b0);
         chk($sformatf("reset u%0d resp_rdata", i), resp_rdata[i], 64'd0);
         chk($sformatf("reset u%0d sram_en", i), sram_en[i], 1'b0);
         chk($sformatf("reset u%0d req_ready", i), req_ready[i], 1'b1);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      fetch(0, 32'h8000_0004, 0, -1);
      fetch(2, 32'h8000_1230, 5, -1);
      fetch(0, 32'h7FFF_FFFC, 0, -1);
      fetch(0, 32'h8001_0000, 0, -1);
      fetch(0, 32'h8000_0002, 0, -1);
      fetch(1, 32'h8000_0040, 0, 1);
      fetch(1, 32'h8000_0008, 0, -1);
      fetch(0, 32'h8000_0100, 4, 2);
      fetch(0, 32'h8000_0200, 0, 0);
      fetch(1, 32'h8000_0300, 0, 2);
      fetch(2, 32'h8000_FFF8, 0, -1);
      fetch(2, 32'h8000_0000, 0, -1);
      fetch(2, 32'h8000_0FF0, 2, -1);
      reset_during_wait(32'h8000_0450);

      for (int n = 0; n < 60; n++) begin
         g         = $urandom_range(0, 2);
         lat       = g + 1;
         cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat + 3)) : -1;
         fetch(g, rand_addr(), int'($urandom_range(0, 3)), cancel_at);
      end
      check_idle("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
